// File: rtl/text_panel_gen_if.sv
// Memory-side bus of the text panel renderer.
// Bundles the prompt memory (char_addr -> char_code) and the font memory
// (font_addr -> font_data). Both memories return data for the address that
// is currently presented. The address registers inside the renderer supply
// the one cycle of latency on each lookup.
//   master : renderer, drives the addresses and receives the data
//   slave  : memories, receive the addresses and return the data
interface text_panel_gen_if #(
    parameter int AW = 9
);
    logic [AW-1:0] char_addr;
    logic [6:0]    char_code;
    logic [10:0]   font_addr;
    logic [7:0]    font_data;

    modport master (
        output char_addr,
        output font_addr,
        input  char_code,
        input  font_data
    );

    modport slave (
        input  char_addr,
        input  font_addr,
        output char_code,
        output font_data
    );
endinterface

// File: rtl/text_panel_gen.sv
// Pipelined VGA text panel renderer.
// Draws a COLS x ROWS grid of 8x16 glyphs with its top-left corner at
// (X0,Y0). Characters before the cursor are drawn green and the rest white.
// The cursor cell gets a blinking underline, and its background flashes red
// for a while after a typing error. A pixel presented on x/y/video_on in
// cycle N appears on rgb_* in cycle N+3.
// Ports:
//   clk, reset_n             pixel clock, asynchronous active-low reset
//   video_on, x, y           visible-area flag and pixel position from sync gen
//   frame_tick               one pulse per frame, during vertical blank
//   cursor_col, cursor_row   next character to type
//   err_pulse                one pulse per mistyped key
//   mem                      prompt/font memory bus (master side)
//   rgb_r, rgb_g, rgb_b      registered pixel colour to the DAC
module text_panel_gen #(
    parameter int COLS         = 64,
    parameter int ROWS         = 5,
    parameter int X0           = 208,
    parameter int Y0           = 208,
    parameter int BLINK_FRAMES = 30,
    parameter int ERR_FRAMES   = 12,
    parameter int AW           = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   video_on,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   frame_tick,
    input  logic [7:0]             cursor_col,
    input  logic [7:0]             cursor_row,
    input  logic                   err_pulse,
    text_panel_gen_if.master       mem,
    output logic [7:0]             rgb_r,
    output logic [7:0]             rgb_g,
    output logic [7:0]             rgb_b
);

    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + 8 * COLS);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + 16 * ROWS);

    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam int EW = $clog2(ERR_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_FRAMES - 1);
    localparam logic [EW-1:0] ERR_LOAD = EW'(ERR_FRAMES);

    localparam logic [23:0] C_BLACK = 24'h000000;
    localparam logic [23:0] C_BG    = 24'h4F4F4F;
    localparam logic [23:0] C_ULINE = 24'hFF9F00;
    localparam logic [23:0] C_WHITE = 24'hFFFFFF;
    localparam logic [23:0] C_RED   = 24'h9F0000;
    localparam logic [23:0] C_GREEN = 24'h00FF00;

    // S0: grid decode of the incoming pixel
    logic [9:0]    x_off;
    logic [9:0]    y_off;
    logic          in_grid;
    logic [6:0]    col;
    logic [5:0]    row;
    logic [AW-1:0] addr;

    always_comb begin
        x_off   = x - 10'(X0);
        y_off   = y - 10'(Y0);
        in_grid = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                  ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
        col     = x_off[9:3];
        row     = y_off[9:4];
        addr    = AW'(32'(row) * 32'(COLS) + 32'(col));
    end

    // S1: prompt lookup in flight; pixel attributes delayed alongside
    logic       s1_vid;
    logic       s1_in;
    logic [6:0] s1_col;
    logic [5:0] s1_row;
    logic [2:0] s1_xb;
    logic [3:0] s1_gr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem.char_addr <= '0;
            s1_vid        <= 1'b0;
            s1_in         <= 1'b0;
            s1_col        <= '0;
            s1_row        <= '0;
            s1_xb         <= '0;
            s1_gr         <= '0;
        end else begin
            // Out-of-grid pixels leave the prompt address alone.
            if (in_grid) begin
                mem.char_addr <= addr;
            end
            s1_vid <= video_on;
            s1_in  <= in_grid;
            s1_col <= col;
            s1_row <= row;
            // Pixel offset inside the cell; equals x[2:0] for an 8-aligned X0.
            s1_xb  <= x_off[2:0];
            s1_gr  <= y_off[3:0];
        end
    end

    // S2: font lookup in flight
    logic       s2_vid;
    logic       s2_in;
    logic [6:0] s2_col;
    logic [5:0] s2_row;
    logic [2:0] s2_xb;
    logic       s2_ul;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem.font_addr <= '0;
            s2_vid        <= 1'b0;
            s2_in         <= 1'b0;
            s2_col        <= '0;
            s2_row        <= '0;
            s2_xb         <= '0;
            s2_ul         <= 1'b0;
        end else begin
            mem.font_addr <= {mem.char_code, s1_gr};
            s2_vid        <= s1_vid;
            s2_in         <= s1_in;
            s2_col        <= s1_col;
            s2_row        <= s1_row;
            s2_xb         <= s1_xb;
            s2_ul         <= (s1_gr[3:1] == 3'b111);
        end
    end

    // Per-frame state: the cursor is only sampled on frame_tick so it never
    // moves part-way down the screen.
    logic [7:0]    sh_col;
    logic [7:0]    sh_row;
    logic [BW-1:0] blink_cnt;
    logic          cursor_vis;
    logic [EW-1:0] err_cnt;
    logic          moved;

    assign moved = (cursor_col != sh_col) || (cursor_row != sh_row);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_col     <= '0;
            sh_row     <= '0;
            blink_cnt  <= '0;
            cursor_vis <= 1'b1;
        end else if (frame_tick) begin
            sh_col <= cursor_col;
            sh_row <= cursor_row;
            // A moving cursor restarts its blink phase fully visible.
            if (moved) begin
                blink_cnt  <= '0;
                cursor_vis <= 1'b1;
            end else if (blink_cnt == BLINK_TC) begin
                blink_cnt  <= '0;
                cursor_vis <= ~cursor_vis;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (err_pulse) begin
            err_cnt <= ERR_LOAD;
        end else if (frame_tick && (err_cnt != '0)) begin
            err_cnt <= err_cnt - 1'b1;
        end
    end

    // Colour selection and output register
    logic        pix_bit;
    logic [7:0]  col_w;
    logic [7:0]  row_w;
    logic        cur_cell;
    logic        typed;
    logic [23:0] colour;

    always_comb begin
        pix_bit  = mem.font_data[3'd7 - s2_xb];
        col_w    = {1'b0, s2_col};
        row_w    = {2'b00, s2_row};
        // An off-grid shadow cursor simply never matches a cell.
        cur_cell = (col_w == sh_col) && (row_w == sh_row);
        typed    = (row_w < sh_row) || ((row_w == sh_row) && (col_w < sh_col));
        colour   = C_BLACK;
        if (!s2_vid) begin
            colour = C_BLACK;
        end else if (!s2_in) begin
            colour = C_BG;
        end else if (cur_cell) begin
            if (s2_ul && cursor_vis) begin
                colour = C_ULINE;
            end else if (pix_bit) begin
                colour = C_WHITE;
            end else if (err_cnt != '0) begin
                colour = C_RED;
            end else begin
                colour = C_BG;
            end
        end else if (pix_bit && typed) begin
            colour = C_GREEN;
        end else if (pix_bit) begin
            colour = C_WHITE;
        end else begin
            colour = C_BG;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {rgb_r, rgb_g, rgb_b} <= 24'h000000;
        end else begin
            {rgb_r, rgb_g, rgb_b} <= colour;
        end
    end

endmodule
